// File: rtl/serial_pkg.sv
// Shared definitions for the 7O1 serial transmitter: FSM encodings (which double
// as debug codes), frame length and the frame-building helper.
package serial_pkg;

  typedef enum logic [3:0] {
    repouso     = 4'h0,
    preparacao  = 4'h1,
    transmissao = 4'h5,
    final_tx    = 4'hF
  } estado_t;

  localparam int         FRAME_BITS  = 10;
  localparam logic [3:0] DB_INVALIDO = 4'hE;

  // Frame as shifted out LSB first: start(0), d0..d6, odd parity, stop(1).
  function automatic logic [FRAME_BITS-1:0] monta_quadro(input logic [6:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

endpackage

// File: rtl/contador_m.sv
// Generic modulo-M counter; fim flags the last count so callers can act on the wrap.
module contador_m #(
  parameter int M = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= (contagem == W'(M - 1)) ? '0 : contagem + W'(1);
    end
  end

  assign fim = (contagem == W'(M - 1));

endmodule

// File: rtl/tx_serial_7o1.sv
// 7O1 asynchronous serial transmitter: captures a character on partida, shifts
// out start/data/parity/stop at DIVISOR clocks per bit, then pulses pronto.
module tx_serial_7o1
  import serial_pkg::*;
#(
  parameter int DIVISOR = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados_ascii,
  output logic       saida_serial,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t               estado, estado_n;
  logic [6:0]            dado, dado_n;
  logic [FRAME_BITS-1:0] quadro, quadro_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic                  zera, conta, fim;

  contador_m #(.M(DIVISOR)) u_tick (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta),
    .fim   (fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= repouso;
      dado         <= '0;
      quadro       <= '1;
      bit_cnt      <= '0;
      saida_serial <= 1'b1;
      pronto       <= 1'b0;
    end else begin
      estado       <= estado_n;
      dado         <= dado_n;
      quadro       <= quadro_n;
      bit_cnt      <= bit_cnt_n;
      // Outputs registered from next-state values so they line up with the state.
      saida_serial <= (estado_n == transmissao) ? quadro_n[0] : 1'b1;
      pronto       <= (estado_n == final_tx);
    end
  end

  always_comb begin
    estado_n  = estado;
    dado_n    = dado;
    quadro_n  = quadro;
    bit_cnt_n = bit_cnt;
    zera      = 1'b0;
    conta     = 1'b0;
    case (estado)
      repouso: begin
        if (partida) begin
          dado_n   = dados_ascii;
          estado_n = preparacao;
        end
      end
      preparacao: begin
        quadro_n  = monta_quadro(dado);
        bit_cnt_n = '0;
        zera      = 1'b1;
        estado_n  = transmissao;
      end
      transmissao: begin
        conta = 1'b1;
        if (fim) begin
          quadro_n = {1'b1, quadro[FRAME_BITS-1:1]};
          // Bit counter stops at 9: the stop bit's last tick ends the frame.
          if (bit_cnt == 4'(FRAME_BITS - 1)) begin
            estado_n = final_tx;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      final_tx: estado_n = repouso;
      default:  estado_n = repouso;
    endcase
  end

  always_comb begin
    case (estado)
      repouso, preparacao, transmissao, final_tx: db_estado = estado;
      default:                                    db_estado = DB_INVALIDO;
    endcase
  end

endmodule

// File: tb/tb_tx_serial_7o1.sv
// Bench for tx_serial_7o1 with DIVISOR=4: a cycle-level expectation queue built
// from the frame rules, checked every cycle, plus directed literal checks.
module tb_tx_serial_7o1;

  localparam int DIV = 4;
  localparam int FRAME_CYC = 10 * DIV;
  localparam int MAXW = 128;

  logic       clock = 1'b0;
  logic       reset;
  logic       partida;
  logic [6:0] dados_ascii;
  logic       saida_serial;
  logic       pronto;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;

  tx_serial_7o1 #(.DIVISOR(DIV)) dut (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .dados_ascii  (dados_ascii),
    .saida_serial (saida_serial),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame bit k of character d (0 = start, 1..7 = data LSB first, 8 = parity, 9 = stop).
  function automatic logic frame_bit(input logic [6:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 7) return d[k-1];
    if (k == 8) return ($countones(d) % 2 == 0);
    return 1'b1;
  endfunction

  function automatic logic [9:0] exp_frame(input logic [6:0] d);
    logic [9:0] f;
    for (int k = 0; k < 10; k++) f[k] = frame_bit(d, k);
    return f;
  endfunction

  // Model: per-cycle expectations {line, pronto, db} pushed when a request is accepted.
  localparam logic [5:0] IDLE = {1'b1, 1'b0, 4'h0};
  logic [5:0] exp_q[$];
  logic [5:0] cur = IDLE;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      cur <= IDLE;
    end else begin
      if (cur[3:0] == 4'h0 && partida === 1'b1) begin
        exp_q.push_back({1'b1, 1'b0, 4'h1});
        for (int k = 0; k < FRAME_CYC; k++)
          exp_q.push_back({frame_bit(dados_ascii, k / DIV), 1'b0, 4'h5});
        exp_q.push_back({1'b1, 1'b1, 4'hF});
      end
      cur <= (exp_q.size() > 0) ? exp_q.pop_front() : IDLE;
    end
  end

  // scoreboard compare process
  always @(negedge clock) begin
    check("model_line", saida_serial, cur[5]);
    check("model_pronto", pronto, cur[4]);
    check("model_db", db_estado, cur[3:0]);
  end

  // Window recorder/driver: cycle 0 has partida=1 and dados_ascii=d.
  logic       line_at [MAXW];
  logic       pr_at   [MAXW];
  logic [3:0] db_at   [MAXW];

  task automatic run_window(input logic [6:0] d, input int hold, input int extra_at,
                            input int chg_at, input logic [6:0] d2, input int len);
    dados_ascii = d;
    partida     = 1'b1;
    for (int n = 1; n <= len; n++) begin
      @(negedge clock);
      line_at[n] = saida_serial;
      pr_at[n]   = pronto;
      db_at[n]   = db_estado;
      partida    = (n < hold) || (n == extra_at);
      if (n == chg_at) dados_ascii = d2;
    end
    partida = 1'b0;
  endtask

  function automatic logic [9:0] decode(input int start);
    logic [9:0] f;
    for (int k = 0; k < 10; k++) f[k] = line_at[start + DIV / 2 + DIV * k];
    return f;
  endfunction

  function automatic int count_pronto(input int len);
    int c = 0;
    for (int n = 1; n <= len; n++) if (pr_at[n]) c++;
    return c;
  endfunction

  function automatic int first_pronto(input int len);
    for (int n = 1; n <= len; n++) if (pr_at[n]) return n;
    return -1;
  endfunction

  initial begin
    logic [9:0] f;
    int         s2;
    int         c;
    logic [6:0] d;
    reset       = 1'b0;
    partida     = 1'b0;
    dados_ascii = 7'h00;

    // Reset: held 3 cycles with partida toggling.
    for (int i = 0; i < 3; i++) begin
      partida = i[0];
      dados_ascii = 7'h7F;
      @(negedge clock);
      check("rst_line", saida_serial, 1'b1);
      check("rst_pronto", pronto, 1'b0);
      check("rst_db", db_estado, 4'h0);
    end
    partida = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_db", db_estado, 4'h0);

    // Single frame 0x41.
    run_window(7'h41, 1, -1, -1, 7'h00, 50);
    check("f41_bits", decode(2), 10'b1110000010);
    check("f41_pronto_cyc", first_pronto(50), 42);
    check("f41_pronto_cnt", count_pronto(50), 1);
    check("f41_db1", db_at[1], 4'h1);
    check("f41_line1", line_at[1], 1'b1);
    check("f41_db2", db_at[2], 4'h5);
    check("f41_db42", db_at[42], 4'hF);
    check("f41_db43", db_at[43], 4'h0);
    check("f41_start_edge", line_at[2], 1'b0);
    check("f41_bit1_edge", line_at[6], 1'b1);

    // Parity corners: bit 8 mid-sample at cycle 2+2+32.
    run_window(7'h00, 1, -1, -1, 7'h00, 46);
    check("par00", line_at[36], 1'b1);
    run_window(7'h7F, 1, -1, -1, 7'h00, 46);
    check("par7f", line_at[36], 1'b0);

    // Back-to-back with partida held and data changed at cycle 10.
    run_window(7'h55, 60, -1, 10, 7'h2A, 95);
    f = decode(2);
    check("b2b_first", f[7:1], 7'h55);
    s2 = -1;
    for (int n = 95; n >= 43; n--) if (line_at[n] == 1'b0 && line_at[n-1] == 1'b1) s2 = n;
    check("b2b_second_start", s2, 45);
    check("b2b_second", decode(45), exp_frame(7'h2A));
    check("b2b_pronto_cnt", count_pronto(95), 2);

    // Mid-frame reset during data bit 3 (frame bit 4, cycles 18..21).
    dados_ascii = 7'h5A;
    partida = 1'b1;
    @(negedge clock);
    partida = 1'b0;
    repeat (18) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("midrst_line", saida_serial, 1'b1);
    check("midrst_pronto", pronto, 1'b0);
    check("midrst_db", db_estado, 4'h0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    c = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (pronto) c++;
    end
    check("midrst_no_pronto", c, 0);
    run_window(7'h3C, 1, -1, -1, 7'h00, 46);
    check("after_rst_frame", decode(2), exp_frame(7'h3C));
    check("after_rst_pronto", first_pronto(46), 42);

    // Request during a frame is ignored.
    run_window(7'h33, 1, 20, -1, 7'h00, 70);
    check("ign_frame", decode(2), exp_frame(7'h33));
    check("ign_pronto_cnt", count_pronto(70), 1);
    c = 0;
    for (int n = 43; n <= 70; n++) if (line_at[n] == 1'b0) c++;
    check("ign_idle_after", c, 0);

    // Randomized frames with random hold lengths and gaps.
    for (int i = 0; i < 10; i++) begin
      d = 7'($urandom_range(0, 127));
      run_window(d, $urandom_range(1, 3), -1, -1, 7'h00, 44);
      check("rnd_frame", decode(2), exp_frame(d));
      check("rnd_pronto", first_pronto(44), 42);
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
